// File: rtl/mem_explorer_pkg.sv
// Shared board constants and address-step helpers for the memory explorer.
package mem_explorer_pkg;

  // Basys-3 gamepad button indices
  localparam int BTN_U   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_R   = 2;
  localparam int BTN_D   = 3;
  localparam int BTN_C   = 4;
  localparam int NUM_BTN = 5;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_RATE     = 10_000_000;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_e;

  // Opposing pulses in the same cycle cancel.
  function automatic step_e step_dir(input logic inc, input logic dec);
    if (inc == dec) return STEP_NONE;
    return inc ? STEP_INC : STEP_DEC;
  endfunction

endpackage

// File: rtl/mem_explorer_debounce.sv
// Button conditioner: 2-flop sync, stable-count debounce, press pulse and
// optional hold-to-repeat pulse train.
module button_debounce_repeat
  import mem_explorer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press,
  output logic repeat_pulse,
  output logic level
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_RATE - 1);

  logic            sync1_q, sync2_q, stable_q, press_q, rpt_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [RP_W-1:0] rp_cnt_q;
  logic            flip;

  assign flip = (sync2_q != stable_q) && (db_cnt_q == DB_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      rpt_q    <= 1'b0;
      db_cnt_q <= '0;
      rp_cnt_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;

      if (sync2_q == stable_q) begin
        db_cnt_q <= '0;
      end else if (flip) begin
        db_cnt_q <= '0;
        stable_q <= sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end

      press_q <= flip && sync2_q;

      // Repeat timer is a down-counter armed on the press edge; the release
      // edge itself must never emit a repeat.
      rpt_q <= 1'b0;
      if (flip && sync2_q) begin
        rp_cnt_q <= RP_FIRST;
      end else if (!stable_q || flip) begin
        rp_cnt_q <= '0;
      end else if (rp_cnt_q == '0) begin
        rp_cnt_q <= RP_NEXT;
        rpt_q    <= REPEAT_EN;
      end else begin
        rp_cnt_q <= rp_cnt_q - 1'b1;
      end
    end
  end

  assign press        = press_q;
  assign repeat_pulse = rpt_q;
  assign level        = stable_q;

endmodule

// File: rtl/mem_explorer.sv
// Memory explorer: debounced buttons step write/read addresses over an
// inferred simple dual-port RAM; commit writes the switch value.
module mem_explorer
  import mem_explorer_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 10,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int WRAP            = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              btn_wr_inc,
  input  logic              btn_wr_dec,
  input  logic              btn_rd_inc,
  input  logic              btn_rd_dec,
  input  logic              btn_commit,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_strobe
);
  logic [NUM_BTN-1:0] btn_raw, btn_press, btn_rpt, btn_pulse, btn_level_unused;
  logic [ADDR_W-1:0]  waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_W-1:0]  rd_data_q;
  logic [DATA_W-1:0]  mem_q [2**ADDR_W];
  logic               wr_en;

  assign btn_raw[BTN_U] = btn_wr_inc;
  assign btn_raw[BTN_D] = btn_wr_dec;
  assign btn_raw[BTN_R] = btn_rd_inc;
  assign btn_raw[BTN_L] = btn_rd_dec;
  assign btn_raw[BTN_C] = btn_commit;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce_repeat #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (i != BTN_C)
    ) u_btn (
      .clk         (clk),
      .reset       (reset),
      .button      (btn_raw[i]),
      .press       (btn_press[i]),
      .repeat_pulse(btn_rpt[i]),
      .level       (btn_level_unused[i])
    );
  end

  assign btn_pulse = btn_press | btn_rpt;
  assign wr_en     = btn_pulse[BTN_C];

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input step_e dir);
    logic [ADDR_W-1:0] nxt;
    nxt = a;
    case (dir)
      STEP_INC: if (WRAP != 0 || a != '1) nxt = a + 1'b1;
      STEP_DEC: if (WRAP != 0 || a != '0) nxt = a - 1'b1;
      default:  nxt = a;
    endcase
    return nxt;
  endfunction

  always_comb begin
    waddr_d = step_addr(waddr_q, step_dir(btn_pulse[BTN_U], btn_pulse[BTN_D]));
    raddr_d = step_addr(raddr_q, step_dir(btn_pulse[BTN_R], btn_pulse[BTN_L]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q   <= '0;
      raddr_q   <= '0;
      rd_data_q <= '0;
    end else begin
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      rd_data_q <= (wr_en && waddr_q == raddr_q) ? sw_data : mem_q[raddr_q];
    end
  end

  // Write uses the pre-step address; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr_q] <= sw_data;
  end

  assign waddr     = waddr_q;
  assign raddr     = raddr_q;
  assign rd_data   = rd_data_q;
  assign wr_strobe = wr_en;

endmodule

// File: tb/tb_mem_explorer.sv
// Scoreboard bench for mem_explorer: one saturating and one wrapping instance.
module tb_mem_explorer;

  localparam logic [4:0] B_WI = 5'b00001;
  localparam logic [4:0] B_WD = 5'b00010;
  localparam logic [4:0] B_RI = 5'b00100;
  localparam logic [4:0] B_RD = 5'b01000;
  localparam logic [4:0] B_C  = 5'b10000;

  logic       clk;
  logic       rst [2];
  logic [7:0] sw [2];
  logic [4:0] btn [2];
  logic [2:0] waddr [2];
  logic [2:0] raddr [2];
  logic [7:0] rd_data [2];
  logic       wr_strobe [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_explorer #(
      .DATA_W(8), .ADDR_W(3), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(g)
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .sw_data   (sw[g]),
      .btn_wr_inc(btn[g][0]),
      .btn_wr_dec(btn[g][1]),
      .btn_rd_inc(btn[g][2]),
      .btn_rd_dec(btn[g][3]),
      .btn_commit(btn[g][4]),
      .waddr     (waddr[g]),
      .raddr     (raddr[g]),
      .rd_data   (rd_data[g]),
      .wr_strobe (wr_strobe[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] w;
    logic [2:0] r;
    logic       s;
  } ev_t;

  typedef struct {
    int         cyc;
    int         g;
    bit         full;
    logic [2:0] w;
    logic [2:0] r;
    logic [7:0] rd;
    logic       s;
  } pr_t;

  ev_t evq0[$];
  ev_t evq1[$];
  pr_t prq[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  bit done   = 1'b0;
  logic [2:0] prev_w [2] = '{3'd0, 3'd0};
  logic [2:0] prev_r [2] = '{3'd0, 3'd0};

  logic [2:0] cur_w [2] = '{3'd0, 3'd0};
  logic [2:0] cur_r [2] = '{3'd0, 3'd0};
  int m0;

  function automatic int ev_size(input int g);
    return (g == 0) ? evq0.size() : evq1.size();
  endfunction

  function automatic ev_t ev_pop(input int g);
    if (g == 0) return evq0.pop_front();
    return evq1.pop_front();
  endfunction

  function automatic int ev_front_cyc(input int g);
    return (g == 0) ? evq0[0].cyc : evq1[0].cyc;
  endfunction

  task automatic push_ev(input int g, input int c, input logic [2:0] w, input logic [2:0] r, input logic s);
    ev_t e;
    e.cyc = c; e.w = w; e.r = r; e.s = s;
    if (g == 0) evq0.push_back(e);
    else        evq1.push_back(e);
  endtask

  task automatic probe(input int g, input int c, input bit full, input logic [2:0] w,
                       input logic [2:0] r, input logic [7:0] rd, input logic s);
    pr_t p;
    p.cyc = c; p.g = g; p.full = full; p.w = w; p.r = r; p.rd = rd; p.s = s;
    prq.push_back(p);
  endtask

  // Monitor: address changes and write strobes are the DUT's observable events.
  task automatic check_dut(input int g);
    ev_t e;
    while (ev_size(g) != 0 && ev_front_cyc(g) < cyc) begin
      e = ev_pop(g);
      total++; bad++;
      $display("FAIL ev_missing dut%0d: nothing seen by cyc %0d, expected w=%0d r=%0d s=%0d at cyc %0d",
               g, cyc, e.w, e.r, e.s, e.cyc);
    end
    if (waddr[g] != prev_w[g] || raddr[g] != prev_r[g] || wr_strobe[g] === 1'b1) begin
      total++;
      if (ev_size(g) == 0) begin
        bad++;
        $display("FAIL ev_unexpected dut%0d cyc %0d: got w=%0d r=%0d s=%0d, expected no event",
                 g, cyc, waddr[g], raddr[g], wr_strobe[g]);
      end else begin
        e = ev_pop(g);
        if (e.cyc != cyc || waddr[g] !== e.w || raddr[g] !== e.r || wr_strobe[g] !== e.s) begin
          bad++;
          $display("FAIL ev_compare dut%0d: got cyc=%0d w=%0d r=%0d s=%0d, expected cyc=%0d w=%0d r=%0d s=%0d",
                   g, cyc, waddr[g], raddr[g], wr_strobe[g], e.cyc, e.w, e.r, e.s);
        end
      end
    end
    prev_w[g] = waddr[g];
    prev_r[g] = raddr[g];
  endtask

  task automatic check_probes();
    pr_t p;
    while (prq.size() != 0 && prq[0].cyc <= cyc) begin
      p = prq.pop_front();
      total++;
      if (p.cyc != cyc) begin
        bad++;
        $display("FAIL probe_missed dut%0d: due cyc %0d, now cyc %0d", p.g, p.cyc, cyc);
      end else if (rd_data[p.g] !== p.rd ||
                   (p.full && (waddr[p.g] !== p.w || raddr[p.g] !== p.r || wr_strobe[p.g] !== p.s))) begin
        bad++;
        $display("FAIL probe dut%0d cyc %0d: got w=%0d r=%0d rd=%02h s=%0d, expected rd=%02h (full=%0d w=%0d r=%0d s=%0d)",
                 p.g, cyc, waddr[p.g], raddr[p.g], rd_data[p.g], wr_strobe[p.g], p.rd, p.full, p.w, p.r, p.s);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 2; g++) check_dut(g);
      check_probes();
    end
    if (done) begin
      while (evq0.size() != 0) begin
        total++; bad++;
        $display("FAIL ev_leftover dut0: expected event at cyc %0d never seen", evq0.pop_front().cyc);
      end
      while (evq1.size() != 0) begin
        total++; bad++;
        $display("FAIL ev_leftover dut1: expected event at cyc %0d never seen", evq1.pop_front().cyc);
      end
      while (prq.size() != 0) begin
        total++; bad++;
        $display("FAIL probe_leftover: probe at cyc %0d never reached", prq.pop_front().cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // A button driven at negedge m is first sampled at edge m+1: press is seen
  // at m+6 (strobe) and the address moves at edge m+7.
  task automatic tap_begin(input int g, input logic [4:0] mask, input logic [2:0] nw, input logic [2:0] nr);
    m0 = cyc;
    if (mask[4]) push_ev(g, m0 + 6, cur_w[g], cur_r[g], 1'b1);
    if (nw != cur_w[g] || nr != cur_r[g]) push_ev(g, m0 + 7, nw, nr, 1'b0);
    cur_w[g] = nw;
    cur_r[g] = nr;
    btn[g] = mask;
  endtask

  task automatic tap_end(input int g);
    repeat (10) @(negedge clk);
    btn[g] = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic tap(input int g, input logic [4:0] mask, input logic [2:0] nw, input logic [2:0] nr);
    tap_begin(g, mask, nw, nr);
    tap_end(g);
  endtask

  initial begin
    rst = '{1'b1, 1'b1};
    sw  = '{8'h00, 8'h00};
    btn = '{5'b0, 5'b0};
    @(negedge clk);
    probe(0, cyc + 1, 1'b1, 3'd0, 3'd0, 8'h00, 1'b0);
    probe(1, cyc + 1, 1'b1, 3'd0, 3'd0, 8'h00, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    rst = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);

    // ---- instance 0: WRAP=0, saturation and repeat ----
    tap(0, B_RD, 3'd0, 3'd0);
    tap(0, B_WD, 3'd0, 3'd0);
    m0 = cyc;
    push_ev(0, m0 + 7,  3'd0, 3'd1, 1'b0);
    push_ev(0, m0 + 27, 3'd0, 3'd2, 1'b0);
    push_ev(0, m0 + 32, 3'd0, 3'd3, 1'b0);
    push_ev(0, m0 + 37, 3'd0, 3'd4, 1'b0);
    push_ev(0, m0 + 42, 3'd0, 3'd5, 1'b0);
    push_ev(0, m0 + 47, 3'd0, 3'd6, 1'b0);
    push_ev(0, m0 + 52, 3'd0, 3'd7, 1'b0);
    btn[0] = B_RI;
    repeat (60) @(negedge clk);
    btn[0] = '0;
    repeat (12) @(negedge clk);
    cur_r[0] = 3'd7;
    tap(0, B_RI, 3'd0, 3'd7);
    tap(0, B_WI | B_WD, 3'd0, 3'd7);
    tap(0, B_RD, 3'd0, 3'd6);

    // ---- instance 1: WRAP=1 ----
    btn[1] = B_WI;
    repeat (3) @(negedge clk);
    btn[1] = '0;
    repeat (10) @(negedge clk);
    tap(1, B_WI, 3'd1, 3'd0);
    tap(1, B_WD, 3'd0, 3'd0);
    tap(1, B_WD, 3'd7, 3'd0);
    tap(1, B_WI | B_WD, 3'd7, 3'd0);
    tap(1, B_WI, 3'd0, 3'd0);
    tap(1, B_WD, 3'd7, 3'd0);
    tap(1, B_WD, 3'd6, 3'd0);
    tap(1, B_WD, 3'd5, 3'd0);
    tap(1, B_WD, 3'd4, 3'd0);
    sw[1] = 8'h3C;
    tap(1, B_C, 3'd4, 3'd0);
    tap(1, B_WD, 3'd3, 3'd0);
    tap(1, B_RI, 3'd3, 3'd1);
    tap(1, B_RI, 3'd3, 3'd2);
    tap(1, B_RI, 3'd3, 3'd3);

    sw[1] = 8'hA5;
    tap_begin(1, B_C, 3'd3, 3'd3);
    probe(1, m0 + 7, 1'b0, 3'd0, 3'd0, 8'hA5, 1'b0);
    tap_end(1);

    tap_begin(1, B_RI, 3'd3, 3'd4);
    probe(1, m0 + 7, 1'b0, 3'd0, 3'd0, 8'hA5, 1'b0);
    probe(1, m0 + 8, 1'b0, 3'd0, 3'd0, 8'h3C, 1'b0);
    tap_end(1);

    tap(1, B_WD, 3'd2, 3'd4);
    sw[1] = 8'h5A;
    tap(1, B_C | B_WI, 3'd3, 3'd4);
    tap_begin(1, B_RD, 3'd3, 3'd3);
    probe(1, m0 + 8, 1'b0, 3'd0, 3'd0, 8'hA5, 1'b0);
    tap_end(1);
    tap_begin(1, B_RD, 3'd3, 3'd2);
    probe(1, m0 + 8, 1'b0, 3'd0, 3'd0, 8'h5A, 1'b0);
    tap_end(1);

    // Reset in the middle of a repeat hold; button stays held throughout.
    m0 = cyc;
    push_ev(1, m0 + 7,  3'd3, 3'd3, 1'b0);
    push_ev(1, m0 + 27, 3'd3, 3'd4, 1'b0);
    push_ev(1, m0 + 32, 3'd3, 3'd5, 1'b0);
    btn[1] = B_RI;
    repeat (34) @(negedge clk);
    rst[1] = 1'b1;
    push_ev(1, m0 + 35, 3'd0, 3'd0, 1'b0);
    probe(1, m0 + 35, 1'b1, 3'd0, 3'd0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst[1] = 1'b0;
    push_ev(1, m0 + 44, 3'd0, 3'd1, 1'b0);
    repeat (13) @(negedge clk);
    btn[1] = '0;
    repeat (12) @(negedge clk);
    cur_w[1] = 3'd0;
    cur_r[1] = 3'd1;

    tap(1, B_RI, 3'd0, 3'd2);
    tap_begin(1, B_RI, 3'd0, 3'd3);
    probe(1, m0 + 8, 1'b0, 3'd0, 3'd0, 8'hA5, 1'b0);
    tap_end(1);

    repeat (5) @(negedge clk);
    done = 1'b1;
  end

endmodule
